// File: rtl/timer_datapath.sv
// Timer datapath: serial MSB-first delay capture plus a (delay+1)*CYCLES_PER_UNIT
// down-counter, driven by the shift_ena/counting strobes of the timer control FSM.
// Optional protocol checker enabled by defining TIMER_PROTO_CHK_EN; it adds the
// sticky proto_err output, which ack clears.
module timer_datapath #(
    parameter int unsigned DELAY_W         = 4,
    parameter int unsigned CYCLES_PER_UNIT = 1000,
    parameter int unsigned SUB_W           = 10
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               data,
    input  logic               shift_ena,
    input  logic               counting,
    input  logic               ack,
    output logic [DELAY_W-1:0] count,
    output logic               done_counting
`ifdef TIMER_PROTO_CHK_EN
    ,
    output logic               proto_err
`endif
);

    localparam logic [SUB_W-1:0]   SubReload = SUB_W'(CYCLES_PER_UNIT - 1);
    localparam logic [DELAY_W-1:0] DelayOne  = DELAY_W'(1);

    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic               sub_zero, delay_zero;

    assign sub_zero   = (sub_q == '0);
    assign delay_zero = (delay_q == '0);

    // Next-state: shift has priority over counting; decrements gated by !=0 checks
    always_comb begin
        delay_d = delay_q;
        sub_d   = sub_q;
        if (shift_ena) begin
            delay_d = {delay_q[DELAY_W-2:0], data};
            sub_d   = SubReload;
        end else if (counting) begin
            if (!sub_zero) begin
                sub_d = sub_q - SUB_W'(1);
            end else if (!delay_zero) begin
                delay_d = delay_q - DelayOne;
                sub_d   = SubReload;
            end
        end
    end

    // Delay and sub-unit registers
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            delay_q <= '0;
            sub_q   <= SubReload;
        end else begin
            delay_q <= delay_d;
            sub_q   <= sub_d;
        end
    end

    assign count         = delay_q;
    assign done_counting = counting & delay_zero & sub_zero;

`ifdef TIMER_PROTO_CHK_EN
    localparam int unsigned      RunW   = $clog2(DELAY_W + 2);
    localparam logic [RunW-1:0]  RunMax = RunW'(DELAY_W + 1);
    localparam logic [RunW-1:0]  RunLim = RunW'(DELAY_W);

    logic [RunW-1:0] run_q, run_d;
    logic            err_q, err_d;
    logic            violation;

    // run_q holds the number of consecutive shift cycles before this one
    assign violation = shift_ena & (counting | (run_q >= RunLim));

    // Consecutive-shift counter and sticky error next-state; new violation beats ack
    always_comb begin
        run_d = '0;
        if (shift_ena) begin
            run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
        end
        err_d = err_q;
        if (violation) begin
            err_d = 1'b1;
        end else if (ack) begin
            err_d = 1'b0;
        end
    end

    // Checker state
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            run_q <= '0;
            err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;
`else
    // ack only matters to the protocol checker
    logic unused_ack;
    assign unused_ack = ack;
`endif

endmodule
